tx_fc_credit_gate: RTL and testbench
====================================

# tx_fc_credit_gate

Transmit-side flow-control credit gate for the TL Tx arbiter, generalised from the fixed two-candidate arbiter/FC exchange to `NUM_REQ` candidates.
- Tracks PCIe Gen5 credit limits (from InitFC/UpdateFC) and credits consumed for Posted, Non-Posted and Completion header/data pools.
- Each cycle, checks up to `NUM_REQ` candidate TLPs in priority order and returns a registered grant mask; granted TLPs consume credits immediately.
- Sits between the Tx arbiter and the DLL-facing FC receive path.

## Interface
Parameters:
- `NUM_REQ`, 2: candidate TLPs checked per cycle (1..4).
- `FC_HDR_WIDTH`, 12: header credit counter width (Gen5 scaled).
- `FC_DATA_WIDTH`, 16: data credit counter width (Gen5 scaled).
- `LEN_WIDTH`, 10: TLP Length field width in DW.

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  clock.
- `arst`  in  1  async reset, active-low.
- `init_valid`  in  1  InitFC value strobe from the DLL.
- `upd_valid`  in  1  UpdateFC value strobe.
- `fc_type`  in  2  pool for init/update: `FC_P`, `FC_NP`, `FC_CPL`.
- `fc_hdr`  in  `FC_HDR_WIDTH`  advertised header limit.
- `fc_data`  in  `FC_DATA_WIDTH`  advertised data limit.
- `req_valid`  in  `NUM_REQ`  candidate valid; bit 0 is highest priority.
- `req_type`  in  `NUM_REQ`×2  candidate pool.
- `req_has_data`  in  `NUM_REQ`  TLP carries payload.
- `req_len`  in  `NUM_REQ`×`LEN_WIDTH`  Length field; 0 encodes 1024 DW.
- `res_valid`  out  1  result strobe.
- `res_grant`  out  `NUM_REQ`  granted candidates.
- `fc_ready`  out  1  all three pools initialised.

## Operation
- State machine `FC_IDLE` → `FC_INIT` → `FC_ACTIVE`.
  - `FC_IDLE` → `FC_INIT` on the first `init_valid`.
  - `FC_INIT` → `FC_ACTIVE` once InitFC has been seen for P, NP and CPL.
  - `fc_ready` is 1 only in `FC_ACTIVE`.
  - Before `FC_ACTIVE`, every valid request fails: `res_valid` = 1, `res_grant` = 0.
- InitFC handling:
  - Loads the pool's header and data limits.
  - A value of 0 sets that field's `infinite` flag.
  - A repeated InitFC for an already-initialised type is ignored.
- UpdateFC handling:
  - Accepted only in `FC_ACTIVE`.
  - Overwrites the limit of non-infinite fields.
  - Has no effect on infinite fields.
- Credits required per candidate:
  - Header: 1.
  - Data: ceil(len/4) when `req_has_data`, else 0; len 0 → 256.
- Fit test per field, mod 2^W: (limit − (consumed + cumulative_required)) mod 2^W ≤ 2^(W−1). An infinite field always passes.
- Priority-prefix grant:
  - Candidate i is granted only if all valid j<i were granted and it fits.
  - `cumulative_required` includes already-granted lower-index candidates of the same pool.
  - The first failure blocks all higher indices (ordering preserved).
  - Invalid slots are skipped and do not block.
- Granted credits are added to `consumed` (mod 2^W) at the same edge the result registers.

## Timing
- Requests sampled at edge t; `res_valid`/`res_grant` are valid in cycle t+1 and stay for one cycle only.
- `res_valid` = OR of `req_valid` sampled at t.
- Consumption is visible to requests at t+1, so back-to-back cycles never double-spend.
- Init/update in the same cycle as a request: the request is checked against the old limit; the new limit applies from t+1.
- Reset values: state `FC_IDLE`; all limits, consumed counters and infinite flags 0; `res_valid` = 0, `res_grant` = 0, `fc_ready` = 0.
- Reset asserted mid-operation clears everything immediately (asynchronously); re-initialisation via InitFC is required.
- Counter wrap: consumed wraps mod 2^W; the fit test stays correct across wrap by the rule above.

## Structure
- `Tx_Arbiter_Package` additions:
  - `fc_type_t` (`FC_P`, `FC_NP`, `FC_CPL`).
  - `fc_state_t`.
  - Constant `FC_TYPES = 3`.
  - Function `data_credits(len, has_data)`.
- Sub-module `tx_fc_pool`, instantiated 3×, one per pool:
  - Holds the header/data limit and consumed registers plus the infinite flags.
  - Exposes the current registers.
  - Accepts per-cycle consumption totals.
- The top level holds the FSM, the combinational prefix-grant chain and the result register.

## Test plan
- Init P=(hdr 4, data 8), NP=(1,0 infinite), CPL=(0,0 infinite) → `fc_ready` 1 one cycle after the third InitFC; requests issued before then → `res_grant`=0.
- Two P requests, len 16 and len 20 with data, P data limit 8 → req0 needs 4, req1 needs 5, cumulative 9 > 8 → `res_grant`=2'b01; consumed data = 4.
- req0 NP (fails, NP hdr 1 with consumed 1), req1 P fits → `res_grant`=2'b00 (prefix blocking).
- Counter wrap: P data limit 0x0002 with consumed 0xFFFE, request len 16 (4 credits) → granted; consumed becomes 0x0002; next request of 1 credit is refused.
- UpdateFC raising P data to 20 in the same cycle as a request of 16 credits against old limit 8 → refused; the same request repeated next cycle → granted.
- Assert `arst` low mid-stream after grants → all outputs 0, `fc_ready` 0, state `FC_IDLE`; requests refused until a fresh InitFC sequence completes.

Source files
------------

// File: rtl/tx_fc_credit_gate_pkg.sv
// Shared types and helpers for the Tx flow-control credit gate.
package tx_fc_credit_gate_pkg;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_type_t;

    typedef enum logic [1:0] {
        FC_IDLE   = 2'd0,
        FC_INIT   = 2'd1,
        FC_ACTIVE = 2'd2
    } fc_state_t;

    localparam int FC_TYPES  = 3;
    localparam int LEN_MAX_W = 16;

    // Data credits are 4 DW units; a zero Length field encodes 2^len_w DW.
    function automatic logic [LEN_MAX_W:0] data_credits(
        input logic [LEN_MAX_W-1:0] len,
        input int                   len_w,
        input logic                 has_data
    );
        logic [LEN_MAX_W+2:0] dw;
        dw = (len == '0) ? ((LEN_MAX_W+3)'(1) << len_w) : (LEN_MAX_W+3)'(len);
        data_credits = has_data ? (LEN_MAX_W+1)'((dw + (LEN_MAX_W+3)'(3)) >> 2) : '0;
    endfunction

endpackage

// File: rtl/tx_fc_pool.sv
// One flow-control pool: advertised header/data limits, consumed counters
// and the infinite-credit flags latched at InitFC time.
module tx_fc_pool #(
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              init_i,
    input  logic              upd_i,
    input  logic [HDR_W-1:0]  hdr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [HDR_W-1:0]  hdr_use_i,
    input  logic [DATA_W-1:0] data_use_i,
    output logic [HDR_W-1:0]  hdr_lim_o,
    output logic [HDR_W-1:0]  hdr_cons_o,
    output logic              hdr_inf_o,
    output logic [DATA_W-1:0] data_lim_o,
    output logic [DATA_W-1:0] data_cons_o,
    output logic              data_inf_o,
    output logic              done_o
);

    logic [HDR_W-1:0]  hdr_lim_q,  hdr_lim_d;
    logic [HDR_W-1:0]  hdr_cons_q, hdr_cons_d;
    logic [DATA_W-1:0] data_lim_q,  data_lim_d;
    logic [DATA_W-1:0] data_cons_q, data_cons_d;
    logic              hdr_inf_q, hdr_inf_d;
    logic              data_inf_q, data_inf_d;
    logic              done_q, done_d;

    always_comb begin
        hdr_lim_d  = hdr_lim_q;
        data_lim_d = data_lim_q;
        hdr_inf_d  = hdr_inf_q;
        data_inf_d = data_inf_q;
        done_d     = done_q;
        // Only the first InitFC of a pool counts; later ones are dropped.
        if (init_i && !done_q) begin
            hdr_lim_d  = hdr_i;
            data_lim_d = data_i;
            hdr_inf_d  = (hdr_i == '0);
            data_inf_d = (data_i == '0);
            done_d     = 1'b1;
        end else if (upd_i) begin
            if (!hdr_inf_q)  hdr_lim_d  = hdr_i;
            if (!data_inf_q) data_lim_d = data_i;
        end
        hdr_cons_d  = hdr_cons_q + hdr_use_i;
        data_cons_d = data_cons_q + data_use_i;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            hdr_lim_q   <= '0;
            hdr_cons_q  <= '0;
            data_lim_q  <= '0;
            data_cons_q <= '0;
            hdr_inf_q   <= 1'b0;
            data_inf_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hdr_lim_q   <= hdr_lim_d;
            hdr_cons_q  <= hdr_cons_d;
            data_lim_q  <= data_lim_d;
            data_cons_q <= data_cons_d;
            hdr_inf_q   <= hdr_inf_d;
            data_inf_q  <= data_inf_d;
            done_q      <= done_d;
        end
    end

    assign hdr_lim_o   = hdr_lim_q;
    assign hdr_cons_o  = hdr_cons_q;
    assign hdr_inf_o   = hdr_inf_q;
    assign data_lim_o  = data_lim_q;
    assign data_cons_o = data_cons_q;
    assign data_inf_o  = data_inf_q;
    assign done_o      = done_q;

endmodule

// File: rtl/tx_fc_credit_gate.sv
// Tx flow-control credit gate: checks NUM_REQ candidates in priority order
// against per-pool credit limits and returns a registered prefix grant mask.
module tx_fc_credit_gate
    import tx_fc_credit_gate_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16,
    parameter int LEN_WIDTH     = 10
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           init_valid,
    input  logic                           upd_valid,
    input  logic [1:0]                     fc_type,
    input  logic [FC_HDR_WIDTH-1:0]        fc_hdr,
    input  logic [FC_DATA_WIDTH-1:0]       fc_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*2-1:0]           req_type,
    input  logic [NUM_REQ-1:0]             req_has_data,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
    output logic                           res_valid,
    output logic [NUM_REQ-1:0]             res_grant,
    output logic                           fc_ready
);

    localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
    localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};

    // Modular fit test: the remaining slack must lie in the lower half of the ring.
    function automatic logic hdr_fits(input logic [FC_HDR_WIDTH-1:0] lim,
                                      input logic [FC_HDR_WIDTH-1:0] cons,
                                      input logic [FC_HDR_WIDTH-1:0] need,
                                      input logic inf);
        logic [FC_HDR_WIDTH-1:0] slack;
        slack = lim - (cons + need);
        return inf || (slack <= HDR_HALF);
    endfunction

    function automatic logic data_fits(input logic [FC_DATA_WIDTH-1:0] lim,
                                       input logic [FC_DATA_WIDTH-1:0] cons,
                                       input logic [FC_DATA_WIDTH-1:0] need,
                                       input logic inf);
        logic [FC_DATA_WIDTH-1:0] slack;
        slack = lim - (cons + need);
        return inf || (slack <= DATA_HALF);
    endfunction

    fc_state_t                state_q, state_d;
    logic                     res_valid_q;
    logic [NUM_REQ-1:0]       res_grant_q, grant_d;
    logic [FC_TYPES-1:0]      pool_done, seen_d;
    logic                     active;

    logic [FC_HDR_WIDTH-1:0]  hdr_lim  [FC_TYPES];
    logic [FC_HDR_WIDTH-1:0]  hdr_cons [FC_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_lim  [FC_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_cons [FC_TYPES];
    logic [FC_TYPES-1:0]      hdr_inf, data_inf;
    logic [FC_HDR_WIDTH-1:0]  use_hdr  [FC_TYPES];
    logic [FC_DATA_WIDTH-1:0] use_data [FC_TYPES];

    assign active = (state_q == FC_ACTIVE);

    for (genvar t = 0; t < FC_TYPES; t++) begin : g_pool
        tx_fc_pool #(
            .HDR_W  (FC_HDR_WIDTH),
            .DATA_W (FC_DATA_WIDTH)
        ) u_pool (
            .clk         (clk),
            .arst        (arst),
            .init_i      (init_valid && (fc_type == 2'(t))),
            .upd_i       (upd_valid && active && (fc_type == 2'(t))),
            .hdr_i       (fc_hdr),
            .data_i      (fc_data),
            .hdr_use_i   (use_hdr[t]),
            .data_use_i  (use_data[t]),
            .hdr_lim_o   (hdr_lim[t]),
            .hdr_cons_o  (hdr_cons[t]),
            .hdr_inf_o   (hdr_inf[t]),
            .data_lim_o  (data_lim[t]),
            .data_cons_o (data_cons[t]),
            .data_inf_o  (data_inf[t]),
            .done_o      (pool_done[t])
        );
        assign seen_d[t] = pool_done[t] || (init_valid && (fc_type == 2'(t)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_IDLE:   if (init_valid) state_d = FC_INIT;
            FC_INIT:   if (&seen_d)    state_d = FC_ACTIVE;
            default:   state_d = state_q;
        endcase
    end

    // Prefix chain: use_* accumulate the credits of candidates granted so far,
    // which is both the cumulative requirement and the consumption to commit.
    always_comb begin
        logic                     blocked;
        logic                     fits;
        logic [1:0]               typ;
        logic [FC_DATA_WIDTH-1:0] need_data;
        grant_d   = '0;
        blocked   = !active;
        fits      = 1'b0;
        typ       = 2'd0;
        need_data = '0;
        for (int t = 0; t < FC_TYPES; t++) begin
            use_hdr[t]  = '0;
            use_data[t] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            typ       = req_type[2*i +: 2];
            need_data = FC_DATA_WIDTH'(data_credits(LEN_MAX_W'(req_len[LEN_WIDTH*i +: LEN_WIDTH]),
                                                    LEN_WIDTH, req_has_data[i]));
            fits = 1'b0;
            if (typ <= 2'(FC_CPL)) begin
                fits = hdr_fits(hdr_lim[typ], hdr_cons[typ], use_hdr[typ] + FC_HDR_WIDTH'(1), hdr_inf[typ])
                    && data_fits(data_lim[typ], data_cons[typ], use_data[typ] + need_data, data_inf[typ]);
            end
            if (req_valid[i]) begin
                if (!blocked && fits) begin
                    grant_d[i]     = 1'b1;
                    use_hdr[typ]   = use_hdr[typ] + FC_HDR_WIDTH'(1);
                    use_data[typ]  = use_data[typ] + need_data;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= FC_IDLE;
            res_valid_q <= 1'b0;
            res_grant_q <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= |req_valid;
            res_grant_q <= grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_grant = res_grant_q;
    assign fc_ready  = active;

endmodule

// File: tb/tb_tx_fc_credit_gate.sv
// Directed bench for tx_fc_credit_gate: vector table plus wrap and reset sequences.
module tb_tx_fc_credit_gate;

    localparam logic [1:0] TP = 2'd0, TNP = 2'd1, TCPL = 2'd2;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        init_valid = 1'b0, upd_valid = 1'b0;
    logic [1:0]  fc_type = 2'd0;
    logic [11:0] fc_hdr = '0;
    logic [15:0] fc_data = '0;
    logic [1:0]  req_valid = '0;
    logic [3:0]  req_type = '0;
    logic [1:0]  req_has_data = '0;
    logic [19:0] req_len = '0;
    logic        res_valid;
    logic [1:0]  res_grant;
    logic        fc_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        init_v;
        logic        upd_v;
        logic [1:0]  fct;
        logic [11:0] hdr;
        logic [15:0] data;
        logic [1:0]  rv;
        logic [3:0]  rtype;
        logic [1:0]  rhd;
        logic [19:0] rlen;
        logic        ev;
        logic [1:0]  eg;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    tx_fc_credit_gate #(
        .NUM_REQ(2), .FC_HDR_WIDTH(12), .FC_DATA_WIDTH(16), .LEN_WIDTH(10)
    ) dut (
        .clk(clk), .arst(arst), .init_valid(init_valid), .upd_valid(upd_valid),
        .fc_type(fc_type), .fc_hdr(fc_hdr), .fc_data(fc_data),
        .req_valid(req_valid), .req_type(req_type), .req_has_data(req_has_data),
        .req_len(req_len), .res_valid(res_valid), .res_grant(res_grant), .fc_ready(fc_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input string nm, input logic iv, input logic uv,
                                input logic [1:0] ft, input logic [11:0] h, input logic [15:0] d,
                                input logic [1:0] rv, input logic [3:0] rt, input logic [1:0] rhd,
                                input logic [19:0] rl, input logic ev, input logic [1:0] eg,
                                input logic er);
        vec_t v;
        v.name = nm; v.init_v = iv; v.upd_v = uv; v.fct = ft; v.hdr = h; v.data = d;
        v.rv = rv; v.rtype = rt; v.rhd = rhd; v.rlen = rl; v.ev = ev; v.eg = eg; v.er = er;
        return v;
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {valid,grant,ready} got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        init_valid   = v.init_v;
        upd_valid    = v.upd_v;
        fc_type      = v.fct;
        fc_hdr       = v.hdr;
        fc_data      = v.data;
        req_valid    = v.rv;
        req_type     = v.rtype;
        req_has_data = v.rhd;
        req_len      = v.rlen;
        @(posedge clk);
        @(negedge clk);
        init_valid = 1'b0;
        upd_valid  = 1'b0;
        req_valid  = '0;
        check(v.name, {res_valid, res_grant, fc_ready}, {v.ev, v.eg, v.er});
    endtask

    logic [15:0] dcons;
    logic [11:0] hcons;

    initial begin
        // name, init, upd, fc_type, hdr, data, req_valid, {t1,t0}, has_data, {len1,len0}, exp valid, grant, ready
        tbl.push_back(mk("pre_init",       0, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TP},    2'b00, {10'd0, 10'd0},     1, 2'b00, 0));
        tbl.push_back(mk("init_p_req",     1, 0, TP,   12'd4,  16'd8,  2'b01, {TP, TP},    2'b00, {10'd0, 10'd0},     1, 2'b00, 0));
        tbl.push_back(mk("init_np_noreq",  1, 0, TNP,  12'd1,  16'd0,  2'b00, {TP, TP},    2'b00, {10'd0, 10'd0},     0, 2'b00, 0));
        tbl.push_back(mk("init_cpl_req",   1, 0, TCPL, 12'd0,  16'd0,  2'b01, {TP, TP},    2'b00, {10'd0, 10'd0},     1, 2'b00, 1));
        tbl.push_back(mk("p_cum_split",    0, 0, TP,   12'd0,  16'd0,  2'b11, {TP, TP},    2'b11, {10'd20, 10'd16},   1, 2'b01, 1));
        tbl.push_back(mk("np_take",        0, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TNP},   2'b00, {10'd0, 10'd1},     1, 2'b01, 1));
        tbl.push_back(mk("np_prefix_blk",  0, 0, TP,   12'd0,  16'd0,  2'b11, {TP, TNP},   2'b00, {10'd1, 10'd1},     1, 2'b00, 1));
        tbl.push_back(mk("skip_invalid",   0, 0, TP,   12'd0,  16'd0,  2'b10, {TP, TNP},   2'b10, {10'd16, 10'd1},    1, 2'b10, 1));
        tbl.push_back(mk("p_data_full",    0, 0, TP,   12'd0,  16'd0,  2'b11, {TCPL, TP},  2'b01, {10'd4, 10'd4},     1, 2'b00, 1));
        tbl.push_back(mk("cpl_infinite",   0, 0, TP,   12'd0,  16'd0,  2'b11, {TCPL, TCPL},2'b11, {10'd0, 10'd0},     1, 2'b11, 1));
        tbl.push_back(mk("upd_same_cycle", 0, 1, TP,   12'd10, 16'd20, 2'b01, {TP, TP},    2'b01, {10'd0, 10'd48},    1, 2'b00, 1));
        tbl.push_back(mk("upd_applied",    0, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TP},    2'b01, {10'd0, 10'd48},    1, 2'b01, 1));
        tbl.push_back(mk("upd_np_old_hdr", 0, 1, TNP,  12'd2,  16'd5,  2'b01, {TP, TNP},   2'b01, {10'd0, 10'd400},   1, 2'b00, 1));
        tbl.push_back(mk("np_data_inf",    0, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TNP},   2'b01, {10'd0, 10'd400},   1, 2'b01, 1));
        tbl.push_back(mk("reinit_ignored", 1, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TP},    2'b01, {10'd0, 10'd4},     1, 2'b00, 1));
        tbl.push_back(mk("still_limited",  0, 0, TP,   12'd0,  16'd0,  2'b01, {TP, TP},    2'b01, {10'd0, 10'd4},     1, 2'b00, 1));
        tbl.push_back(mk("no_request",     0, 0, TP,   12'd0,  16'd0,  2'b00, {TCPL, TCPL},2'b11, {10'd0, 10'd0},     0, 2'b00, 1));

        repeat (3) @(negedge clk);
        check("reset_state", {res_valid, res_grant, fc_ready}, 4'b0000);
        arst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i]);

        // P pool now: hdr limit 10 consumed 3, data limit 20 consumed 20.
        hcons = 12'd3;
        dcons = 16'd20;
        for (int k = 0; k < 255; k++) begin
            run_vec(mk("wrap_upd", 0, 1, TP, hcons + 12'd1, dcons + 16'd256, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 1));
            run_vec(mk("wrap_fill", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd0}, 1, 2'b01, 1));
            hcons = hcons + 12'd1;
            dcons = dcons + 16'd256;
        end
        run_vec(mk("wrap_upd_fffe", 0, 1, TP, hcons + 12'd1, 16'hFFFE, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 1));
        run_vec(mk("wrap_to_fffe", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd936}, 1, 2'b01, 1));
        hcons = hcons + 12'd1;
        run_vec(mk("wrap_upd_0002", 0, 1, TP, hcons + 12'd2, 16'h0002, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 1));
        run_vec(mk("wrap_cross", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd16}, 1, 2'b01, 1));
        run_vec(mk("wrap_refuse", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd4}, 1, 2'b00, 1));

        // Mid-stream asynchronous reset while a grant is on the outputs.
        run_vec(mk("pre_reset_grant", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TCPL}, 2'b01, {10'd0, 10'd8}, 1, 2'b01, 1));
        #2 arst = 1'b0;
        #1 check("async_reset", {res_valid, res_grant, fc_ready}, 4'b0000);
        @(negedge clk);
        arst = 1'b1;
        run_vec(mk("post_reset_req", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TCPL}, 2'b01, {10'd0, 10'd8}, 1, 2'b00, 0));
        run_vec(mk("reinit_p",   1, 0, TP,   12'd4, 16'd8, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 0));
        run_vec(mk("reinit_np",  1, 0, TNP,  12'd1, 16'd0, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 0));
        run_vec(mk("reinit_cpl", 1, 0, TCPL, 12'd0, 16'd0, 2'b00, {TP, TP}, 2'b00, 20'd0, 0, 2'b00, 1));
        run_vec(mk("fresh_grant", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd16}, 1, 2'b01, 1));
        run_vec(mk("fresh_limit", 0, 0, TP, 12'd0, 16'd0, 2'b01, {TP, TP}, 2'b01, {10'd0, 10'd20}, 1, 2'b00, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
